// File: rtl/ppu_frame_writer_if.sv
// ---------------------------------------------------------------------------
// ppu_frame_writer_if
//
// Bundles the two streaming sides of the frame writer:
//   - pixel stream from the PPU FIFO : px_in (2-bit colour index), px_valid
//   - display scan-out read port     : rd_en, rd_addr -> rd_data, rd_valid
//
// Modports:
//   master : the upstream/downstream logic (drives pixels and read requests)
//   slave  : the frame writer (consumes pixels, returns read data)
// ---------------------------------------------------------------------------
interface ppu_frame_writer_if #(
    parameter int ADDR_W = 15
) ();

    logic [1:0]        px_in;
    logic              px_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_data;
    logic              rd_valid;

    modport master (
        output px_in,
        output px_valid,
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  px_in,
        input  px_valid,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid
    );

endinterface

// File: rtl/ppu_frame_writer.sv
// ---------------------------------------------------------------------------
// ppu_frame_writer
//
// Takes the background colour-index stream coming out of the PPU pixel
// pipeline, maps every index through the BGP palette and stores the resulting
// 2-bit shades into the back half of a double-buffered H_PIXELS x V_LINES
// frame store. At V-blank entry a complete frame swaps the buffers, so the
// display scan-out only ever reads a finished frame from the front buffer.
//
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   lcd_en      : LCDC bit 7, display enabled
//   ppu_mode    : 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
//   bgp         : BGP palette register
//   frame_done  : one-cycle pulse when the buffers swap
//   err_flags   : sticky [0] pixel overflow, [1] short line, [2] incomplete frame
//   err_clr     : clears err_flags (a simultaneous set event wins)
//   bus (slave) : px_in/px_valid pixel stream, rd_en/rd_addr -> rd_data/rd_valid
//                 read port with one cycle of latency
// ---------------------------------------------------------------------------
module ppu_frame_writer #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lcd_en,
    input  logic [1:0]          ppu_mode,
    input  logic [7:0]          bgp,
    output logic                frame_done,
    output logic [2:0]          err_flags,
    input  logic                err_clr,
    ppu_frame_writer_if.slave   bus
);

    localparam int                DEPTH       = H_PIXELS * V_LINES;
    localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] H_PIX_A     = ADDR_W'(H_PIXELS);
    localparam logic [7:0]        X_LAST      = 8'(H_PIXELS - 1);
    localparam logic [7:0]        Y_END       = 8'(V_LINES);
    localparam logic [1:0]        MODE_VBLANK = 2'd1;
    localparam logic [1:0]        MODE_DRAW   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LINE,
        ST_ACTIVE,
        ST_LINE_DONE
    } state_t;

    state_t      state_reg;
    logic [7:0]  x_reg;
    logic [7:0]  y_reg;
    logic        bank_sel_reg;      // front bank index; back bank is ~bank_sel_reg
    logic [1:0]  prev_mode_reg;

    // Read-path control registers, captured alongside the RAM read so the
    // output mux selects the bank that was front in the request cycle.
    logic        rd_sel_reg;
    logic        rd_zero_reg;
    logic        rd_valid_reg;

    // Decoded per-cycle events
    logic        in_draw;
    logic        draw_entry;
    logic        vblank_entry;
    logic        line_open;
    logic        wr_en;
    logic        px_drop;
    logic        short_line;
    logic [7:0]  y_after;
    logic        frame_ok;
    logic        frame_bad;

    logic [1:0]        shade;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    logic              rd_in_range;

    // -----------------------------------------------------------------------
    // Palette lookup and write address
    // -----------------------------------------------------------------------
    assign shade   = bgp[{bus.px_in, 1'b0} +: 2];
    assign x_ext   = ADDR_W'(x_reg);
    assign y_ext   = ADDR_W'(y_reg);
    assign wr_addr = y_ext * H_PIX_A + x_ext;

    assign rd_in_range = bus.rd_addr < DEPTH_A;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    always_comb begin
        in_draw      = (ppu_mode == MODE_DRAW);
        draw_entry   = (prev_mode_reg != MODE_DRAW) && in_draw;
        vblank_entry = lcd_en && (prev_mode_reg != MODE_VBLANK)
                       && (ppu_mode == MODE_VBLANK);
        line_open    = (y_reg < Y_END);

        // Pixels are only taken while ACTIVE inside a DRAW window on a line
        // that still belongs to the visible frame.
        wr_en = lcd_en && (state_reg == ST_ACTIVE) && in_draw
                && bus.px_valid && line_open;

        // Any other valid pixel while enabled is an overflow. IDLE ignores
        // pixels silently because the display is off or just coming up.
        px_drop = lcd_en && bus.px_valid
                  && ((state_reg == ST_WAIT_LINE)
                      || (state_reg == ST_LINE_DONE)
                      || ((state_reg == ST_ACTIVE) && !(in_draw && line_open)));

        short_line = lcd_en && (state_reg == ST_ACTIVE) && !in_draw
                     && (x_reg != 8'd0);

        // Frame-end decision uses the line count after this cycle's line
        // logic, so a short line closing straight into V-blank still counts.
        y_after   = short_line ? (y_reg + 8'd1) : y_reg;
        frame_ok  = vblank_entry && (y_after == Y_END);
        frame_bad = vblank_entry && !frame_ok;
    end

    // -----------------------------------------------------------------------
    // Line/frame state machine
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            x_reg         <= 8'd0;
            y_reg         <= 8'd0;
            bank_sel_reg  <= 1'b0;
            prev_mode_reg <= 2'd0;
            frame_done    <= 1'b0;
            err_flags     <= 3'b000;
        end else begin
            prev_mode_reg <= ppu_mode;
            frame_done    <= 1'b0;
            err_flags     <= (err_clr ? 3'b000 : err_flags)
                             | {frame_bad, short_line, px_drop};

            if (!lcd_en) begin
                state_reg <= ST_IDLE;
                x_reg     <= 8'd0;
                y_reg     <= 8'd0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_WAIT_LINE;
                    end

                    ST_WAIT_LINE: begin
                        if (draw_entry) begin
                            x_reg     <= 8'd0;
                            state_reg <= ST_ACTIVE;
                        end
                    end

                    ST_ACTIVE: begin
                        if (!in_draw) begin
                            // A DRAW window that ends before the line is
                            // full still consumes a line slot.
                            x_reg     <= 8'd0;
                            state_reg <= ST_WAIT_LINE;
                            if (x_reg != 8'd0) begin
                                y_reg <= y_reg + 8'd1;
                            end
                        end else if (wr_en) begin
                            if (x_reg == X_LAST) begin
                                x_reg     <= 8'd0;
                                y_reg     <= y_reg + 8'd1;
                                state_reg <= ST_LINE_DONE;
                            end else begin
                                x_reg <= x_reg + 8'd1;
                            end
                        end
                    end

                    ST_LINE_DONE: begin
                        if (!in_draw) begin
                            state_reg <= ST_WAIT_LINE;
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase

                // V-blank entry overrides whatever the line logic decided.
                if (vblank_entry) begin
                    x_reg     <= 8'd0;
                    y_reg     <= 8'd0;
                    state_reg <= ST_WAIT_LINE;
                    if (frame_ok) begin
                        bank_sel_reg <= ~bank_sel_reg;
                        frame_done   <= 1'b1;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame store: two banks, each a simple dual-port RAM with registered read
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [1:0] mem [DEPTH];
            logic [1:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && (bank_sel_reg != 1'(gi))) begin
                    mem[wr_addr] <= shade;
                end
                if (bus.rd_en && rd_in_range) begin
                    rd_q <= mem[bus.rd_addr];
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read port control. rd_zero_reg starts set so rd_data is 0 out of reset
    // without having to reset the RAM output registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_sel_reg   <= 1'b0;
            rd_zero_reg  <= 1'b1;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel_reg  <= bank_sel_reg;
                rd_zero_reg <= !rd_in_range;
            end
        end
    end

    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_zero_reg ? 2'b00
                        : (rd_sel_reg ? g_bank[1].rd_q : g_bank[0].rd_q);

endmodule

// File: tb/tb_ppu_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_ppu_frame_writer
//
// Directed bench for ppu_frame_writer. Drives whole frames of DRAW windows,
// short lines, overflowing lines, display disable and reset mid-frame, and
// reads back the front buffer with hand-computed shades.
// ---------------------------------------------------------------------------
module tb_ppu_frame_writer;

    localparam int H  = 160;
    localparam int V  = 144;
    localparam int AW = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_en;
    logic [1:0] ppu_mode;
    logic [7:0] bgp;
    logic       frame_done;
    logic [2:0] err_flags;
    logic       err_clr;

    int checks = 0;
    int errors = 0;

    ppu_frame_writer_if #(.ADDR_W(AW)) bus_if ();

    ppu_frame_writer #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_en     (lcd_en),
        .ppu_mode   (ppu_mode),
        .bgp        (bgp),
        .frame_done (frame_done),
        .err_flags  (err_flags),
        .err_clr    (err_clr),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One DRAW window: SCAN cycle, DRAW entry cycle, n pixels, H_BLANK exit.
    // Pixels beyond the line width carry the index 'extra'.
    task automatic draw_line(input int n, input logic [1:0] extra);
        ppu_mode        = 2'd2;
        bus_if.px_valid = 1'b0;
        tick();
        ppu_mode = 2'd3;
        tick();
        for (int i = 0; i < n; i++) begin
            bus_if.px_valid = 1'b1;
            bus_if.px_in    = (i >= H) ? extra : 2'(i % 4);
            tick();
        end
        bus_if.px_valid = 1'b0;
        ppu_mode        = 2'd0;
        tick();
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [1:0] exp);
        logic [1:0] d;
        logic       v;
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = AW'(addr);
        tick();
        d = bus_if.rd_data;
        v = bus_if.rd_valid;
        bus_if.rd_en = 1'b0;
        $display("RD %s addr=%0d data=%0d valid=%0d", tag, addr, d, v);
        chk(tag, 32'(d), 32'(exp));
        chk({tag, "_valid"}, 32'(v), 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        lcd_en          = 1'b0;
        ppu_mode        = 2'd0;
        bgp             = 8'hE4;
        err_clr         = 1'b0;
        bus_if.px_in    = 2'd0;
        bus_if.px_valid = 1'b0;
        bus_if.rd_en    = 1'b0;
        bus_if.rd_addr  = '0;
        tick();
        tick();

        // Reset state
        chk("rst_rd_data",    32'(bus_if.rd_data),  32'd0);
        chk("rst_rd_valid",   32'(bus_if.rd_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done),      32'd0);
        chk("rst_err",        32'(err_flags),       32'd0);
        rst    = 1'b0;
        lcd_en = 1'b1;

        // Display disabled mid-line with pixels toggling and a V-blank edge
        ppu_mode = 2'd2;
        tick();
        ppu_mode = 2'd3;
        tick();
        for (int i = 0; i < 50; i++) begin
            bus_if.px_valid = 1'b1;
            bus_if.px_in    = 2'(i % 4);
            tick();
        end
        lcd_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus_if.px_valid = i[0];
            ppu_mode        = (i < 5) ? 2'd3 : 2'd1;
            tick();
            if (i == 5) chk("lcd_off_frame_done", 32'(frame_done), 32'd0);
        end
        chk("lcd_off_err", 32'(err_flags), 32'd0);
        bus_if.px_valid = 1'b0;
        ppu_mode        = 2'd0;
        lcd_en          = 1'b1;
        tick();

        // Reset in the middle of a frame
        for (int l = 0; l < 5; l++) draw_line(H, 2'd0);
        ppu_mode = 2'd2;
        tick();
        ppu_mode = 2'd3;
        tick();
        for (int i = 0; i < 20; i++) begin
            bus_if.px_valid = 1'b1;
            bus_if.px_in    = 2'(i % 4);
            tick();
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.px_valid = i[0];
            tick();
        end
        rst             = 1'b0;
        bus_if.px_valid = 1'b0;
        ppu_mode        = 2'd0;
        tick();
        chk("midrst_err",        32'(err_flags),  32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);

        // Frame A: bgp=E4, full frame, must swap from a clean start
        bgp = 8'hE4;
        for (int l = 0; l < V; l++) draw_line(H, 2'd0);
        ppu_mode = 2'd1;
        tick();
        $display("FRAME A frame_done=%0d err=%b", frame_done, err_flags);
        chk("A_frame_done", 32'(frame_done), 32'd1);
        chk("A_err",        32'(err_flags),  32'd0);
        tick();
        chk("A_pulse_end",  32'(frame_done), 32'd0);
        rd_chk("A_addr1",   1,     2'd1);
        rd_chk("A_addr163", 163,   2'd3);
        rd_chk("A_oor",     H * V, 2'd0);
        rd_chk("A_addr163b", 163,  2'd3);
        tick();
        chk("idle_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("idle_rd_hold",  32'(bus_if.rd_data),  32'd3);

        // Frame B: bgp=1B, short line 0, overflowing line 1, rest full
        bgp = 8'h1B;
        draw_line(100, 2'd0);
        chk("B_short_err", 32'(err_flags), 32'b010);
        draw_line(H + 1, 2'd3);
        chk("B_ovf_err",   32'(err_flags), 32'b011);
        for (int l = 2; l < V; l++) draw_line(H, 2'd0);
        rd_chk("B_prefront", 1, 2'd1);

        // Read issued in the swap cycle sees the pre-swap front bank
        ppu_mode       = 2'd1;
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = AW'(1);
        tick();
        bus_if.rd_en = 1'b0;
        $display("FRAME B frame_done=%0d swap_read=%0d err=%b",
                 frame_done, bus_if.rd_data, err_flags);
        chk("B_frame_done", 32'(frame_done),     32'd1);
        chk("B_swap_read",  32'(bus_if.rd_data), 32'd1);
        tick();
        chk("B_pulse_end",  32'(frame_done),     32'd0);
        rd_chk("B_addr1",   1,   2'd2);
        rd_chk("B_addr0",   0,   2'd3);
        rd_chk("B_addr3",   3,   2'd0);
        rd_chk("B_addr160", 160, 2'd3);
        rd_chk("B_addr320", 320, 2'd3);
        rd_chk("B_addr321", 321, 2'd2);
        chk("B_err", 32'(err_flags), 32'b011);

        // Error clear, then clear coinciding with an overflow event
        err_clr = 1'b1;
        tick();
        chk("clr_err", 32'(err_flags), 32'd0);
        bus_if.px_valid = 1'b1;
        tick();
        chk("clr_vs_set_err", 32'(err_flags), 32'b001);
        bus_if.px_valid = 1'b0;
        tick();
        chk("clr_again_err", 32'(err_flags), 32'd0);
        err_clr = 1'b0;

        // Frame C: only 100 lines before V-blank, no swap
        bgp = 8'hE4;
        for (int l = 0; l < 100; l++) draw_line(H, 2'd0);
        ppu_mode = 2'd1;
        tick();
        $display("FRAME C frame_done=%0d err=%b", frame_done, err_flags);
        chk("C_frame_done", 32'(frame_done), 32'd0);
        chk("C_err",        32'(err_flags),  32'b100);
        tick();
        chk("C_frame_done2", 32'(frame_done), 32'd0);
        rd_chk("C_addr0", 0, 2'd3);
        rd_chk("C_addr1", 1, 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
